// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants used by every pipeline stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_read_port.sv
// One register-file read port: address select, R0 zero-force, optional WB write-through (REG_FILE_WRITE_BYPASS_EN).
// Latency: combinational, zero cycles.
// Backpressure: none; the port always returns data for the presented address.
module reg_file_read_port #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                src,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  mem,
    input  logic                             wb_en,
    input  logic [ADDR_W-1:0]                wb_dest,
    input  logic [DATA_W-1:0]                wb_value,
    output logic [DATA_W-1:0]                rd_data
);
    import mips_pkg::*;

    logic src_is_zero;

    assign src_is_zero = (src == ADDR_W'(ZERO_REG));

`ifdef REG_FILE_WRITE_BYPASS_EN
    logic bypass_hit;

    // Reset suppresses the bypass so the port reads zero throughout reset.
    assign bypass_hit = !rst && wb_en && (wb_dest != ADDR_W'(ZERO_REG)) && (wb_dest == src);

    always_comb begin
        rd_data = mem[src];
        if (bypass_hit) begin
            rd_data = wb_value;
        end
        if (src_is_zero) begin
            rd_data = '0;
        end
    end
`else
    logic unused_bypass_inputs;

    assign unused_bypass_inputs = ^{rst, wb_en, wb_dest, wb_value};

    always_comb begin
        rd_data = mem[src];
        if (src_is_zero) begin
            rd_data = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS GPR file: two combinational read ports for ID, one write port for WB, R0 hardwired to zero; optional write-through via REG_FILE_WRITE_BYPASS_EN.
// Latency: reads zero cycles, writes visible after one rising edge (same cycle with bypass enabled).
// Backpressure: none; every WB write is accepted, hazards are resolved by the hazard unit stalling ID.
module reg_file #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    input  logic              WB_EN,
    input  logic [ADDR_W-1:0] WB_Dest,
    input  logic [DATA_W-1:0] WB_Value,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import mips_pkg::*;

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;
    logic                            wr_fire;

    // Entry 0 is never written, so it stays at its reset value of zero.
    assign wr_fire = WB_EN && (WB_Dest != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_fire) begin
            mem[WB_Dest] <= WB_Value;
        end
    end

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_read_port_a (
        .rst      (rst),
        .src      (src1),
        .mem      (mem),
        .wb_en    (WB_EN),
        .wb_dest  (WB_Dest),
        .wb_value (WB_Value),
        .rd_data  (reg1)
    );

    reg_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_read_port_b (
        .rst      (rst),
        .src      (src2),
        .mem      (mem),
        .wb_en    (WB_EN),
        .wb_dest  (WB_Dest),
        .wb_value (WB_Value),
        .rd_data  (reg2)
    );

    // Debug port always shows committed storage, never the bypassed value.
    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  src1, src2, WB_Dest, dbg_addr;
    logic [31:0] reg1, reg2, dbg_data, WB_Value;
    logic        WB_EN;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .src1     (src1),
        .src2     (src2),
        .reg1     (reg1),
        .reg2     (reg2),
        .WB_EN    (WB_EN),
        .WB_Dest  (WB_Dest),
        .WB_Value (WB_Value),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Expected read-port value from the architectural rules and the current WB inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0 || rst) return 32'h0;
`ifdef REG_FILE_WRITE_BYPASS_EN
        if (WB_EN && WB_Dest != 5'd0 && WB_Dest == a) return WB_Value;
`endif
        return model[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, commit the write to the model, and return at the falling edge.
    task automatic edge_step();
        @(posedge clk);
        if (!rst && WB_EN && WB_Dest != 5'd0) model[WB_Dest] = WB_Value;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        logic [31:0] exp_before;
        rst = 1'b1; WB_EN = 1'b0; WB_Dest = '0; WB_Value = '0;
        src1 = '0; src2 = '0; dbg_addr = '0;
        clear_model();

        // Reset state: every address reads zero on all ports.
        #2;
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a); src1 = 5'(a); src2 = 5'(31 - a);
            #1;
            chk("reset_dbg", dbg_data, 32'h0);
            chk("reset_reg1", reg1, 32'h0);
            chk("reset_reg2", reg2, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read of R7 on both ports.
        WB_EN = 1'b1; WB_Dest = 5'd7; WB_Value = 32'h1234_5678;
        edge_step();
        WB_EN = 1'b0; src1 = 5'd7; src2 = 5'd7;
        #1;
        chk("wr7_reg1", reg1, 32'h1234_5678);
        chk("wr7_reg2", reg2, 32'h1234_5678);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk("wr7_others", dbg_data, (a == 7) ? 32'h1234_5678 : 32'h0);
        end

        // R0 protection, including during the write cycle itself.
        @(negedge clk);
        WB_EN = 1'b1; WB_Dest = 5'd0; WB_Value = 32'hFFFF_FFFF; src1 = 5'd0; src2 = 5'd0;
        #1;
        chk("r0_same_cycle", reg1, 32'h0);
        edge_step();
        WB_EN = 1'b0; dbg_addr = 5'd0;
        #1;
        chk("r0_reg1", reg1, 32'h0);
        chk("r0_reg2", reg2, 32'h0);
        chk("r0_dbg", dbg_data, 32'h0);

        // Same-cycle read/write of R9: old 0x11, new 0x22.
        @(negedge clk);
        WB_EN = 1'b1; WB_Dest = 5'd9; WB_Value = 32'h11;
        edge_step();
        WB_Value = 32'h22; src2 = 5'd9; dbg_addr = 5'd9;
        #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
        chk("r9_write_cycle", reg2, 32'h22);
`else
        chk("r9_write_cycle", reg2, 32'h11);
`endif
        chk("r9_dbg_unbypassed", dbg_data, 32'h11);
        edge_step();
        WB_EN = 1'b0;
        #1;
        chk("r9_after_edge", reg2, 32'h22);
        chk("r9_dbg_after", dbg_data, 32'h22);

        // WB_EN=0 must neither write nor bypass.
        @(negedge clk);
        WB_EN = 1'b0; WB_Dest = 5'd3; WB_Value = 32'hAAAA; src1 = 5'd3; dbg_addr = 5'd3;
        #1;
        chk("wben0_same_cycle", reg1, 32'h0);
        edge_step();
        #1;
        chk("wben0_reg1", reg1, 32'h0);
        chk("wben0_dbg", dbg_data, 32'h0);

        // Mid-run asynchronous reset with a pending write that must be discarded.
        @(negedge clk);
        WB_EN = 1'b1; WB_Dest = 5'd5; WB_Value = 32'hDEAD_BEEF;
        edge_step();
        WB_EN = 1'b0; dbg_addr = 5'd5; src1 = 5'd5;
        #1;
        chk("r5_before_reset", dbg_data, 32'hDEAD_BEEF);
        #1;
        rst = 1'b1; WB_EN = 1'b1; WB_Dest = 5'd5; WB_Value = 32'hCAFE_F00D;
        clear_model();
        #1;
        chk("async_reset_dbg", dbg_data, 32'h0);
        chk("async_reset_reg1", reg1, 32'h0);
        chk("async_reset_model", reg1, exp_rd(5'd5));
        edge_step();
        chk("reset_write_dropped", dbg_data, 32'h0);
        rst = 1'b0; WB_EN = 1'b0;
        #1;
        chk("post_reset_reg1", reg1, 32'h0);
        @(negedge clk);
        WB_EN = 1'b1; WB_Dest = 5'd5; WB_Value = 32'h55;
        edge_step();
        WB_EN = 1'b0;
        #1;
        chk("first_write_after_reset", reg1, 32'h55);

        // Sweep R1..R31 on consecutive edges, then read mirrored pairs.
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            WB_EN = 1'b1; WB_Dest = 5'(i); WB_Value = 32'h100 + 32'(i);
            edge_step();
        end
        WB_EN = 1'b0;
        for (int i = 0; i < 32; i++) begin
            src1 = 5'(i); src2 = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            chk("sweep_reg1", reg1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
            chk("sweep_reg2", reg2, (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i));
            chk("sweep_dbg", dbg_data, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
        end

        // Randomized traffic, biased so reads often hit the register being written.
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            WB_EN    = 1'($urandom_range(0, 3) != 0);
            WB_Dest  = 5'($urandom_range(0, 31));
            WB_Value = $urandom;
            src1     = ($urandom_range(0, 2) == 0) ? WB_Dest : 5'($urandom_range(0, 31));
            src2     = ($urandom_range(0, 3) == 0) ? src1 : 5'($urandom_range(0, 31));
            dbg_addr = ($urandom_range(0, 2) == 0) ? WB_Dest : 5'($urandom_range(0, 31));
            #1;
            chk("rand_reg1", reg1, exp_rd(src1));
            chk("rand_reg2", reg2, exp_rd(src2));
            chk("rand_dbg", dbg_data, model[dbg_addr]);
            exp_before = model[dbg_addr];
            edge_step();
            if (n % 50 == 49) begin
                WB_EN = 1'b0;
                #1;
                chk("rand_dbg_commit", dbg_data, model[dbg_addr]);
                if (exp_before !== model[dbg_addr]) chk("rand_commit_changed", dbg_data, WB_Value);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
